mem_port_arbiter: RTL and testbench

- Shares the single main-memory port between the instruction-cache refill path and the data-cache refill/write-back path.
- Runs line-sized, multi-beat bursts and routes each beat's data to the owning requester.
- Sits between the IF/MEM cache controllers and external memory.
- Its grant and done outputs are the cache controllers' miss-wait signals, which feed the hazard unit's stall inputs.

---
 rtl/mem_port_arbiter.sv | 107 ++++++++++
 tb/tb_mem_port_arbiter.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single main-memory port between I-cache refills and D-cache refills/write-backs, running line bursts.
// Grant follows one cycle after the request is sampled in IDLE; beat strobes are combinational on mem_ready_i; mem stalls hold all outputs.
module mem_port_arbiter #(
    parameter  int ADDR_W = 32,
    parameter  int DATA_W = 32,
    parameter  int BEATS  = 4,
    localparam int BW     = $clog2(BEATS)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              ic_req_i,
    input  logic [ADDR_W-1:0] ic_addr_i,
    output logic              ic_gnt_o,
    output logic              ic_rvalid_o,
    output logic              ic_done_o,
    input  logic              dc_req_i,
    input  logic              dc_we_i,
    input  logic [ADDR_W-1:0] dc_addr_i,
    input  logic [DATA_W-1:0] dc_wdata_i,
    output logic              dc_gnt_o,
    output logic              dc_rvalid_o,
    output logic              dc_wnext_o,
    output logic              dc_done_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic [BW-1:0]     beat_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_ready_i,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    localparam int OFF_W = BW + 2;

    typedef enum logic [1:0] {IDLE, IC_XFER, DC_XFER} state_e;

    state_e            state_q;
    logic [BW-1:0]     beat_q;
    logic              last_dc_q;
    logic              we_q;
    logic [ADDR_W-1:0] base_q;

    logic xfer;
    logic beat_done;
    logic last_beat;

    assign xfer      = (state_q != IDLE);
    assign beat_done = xfer && mem_ready_i;
    assign last_beat = beat_done && (beat_q == BW'(BEATS - 1));

    // D-cache wins ties unless it owned the previous burst, so fetch cannot be starved.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            beat_q    <= '0;
            last_dc_q <= 1'b0;
            we_q      <= 1'b0;
            base_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (dc_req_i && (!ic_req_i || !last_dc_q)) begin
                        state_q   <= DC_XFER;
                        base_q    <= {dc_addr_i[ADDR_W-1:OFF_W], OFF_W'(0)};
                        we_q      <= dc_we_i;
                        beat_q    <= '0;
                        last_dc_q <= 1'b1;
                    end else if (ic_req_i) begin
                        state_q   <= IC_XFER;
                        base_q    <= {ic_addr_i[ADDR_W-1:OFF_W], OFF_W'(0)};
                        we_q      <= 1'b0;
                        beat_q    <= '0;
                        last_dc_q <= 1'b0;
                    end
                end
                default: begin
                    if (beat_done) begin
                        beat_q <= beat_q + 1'b1;
                        if (beat_q == BW'(BEATS - 1)) begin
                            state_q <= IDLE;
                        end
                    end
                end
            endcase
        end
    end

    assign ic_gnt_o    = (state_q == IC_XFER);
    assign dc_gnt_o    = (state_q == DC_XFER);
    assign ic_rvalid_o = ic_gnt_o && mem_ready_i;
    assign dc_rvalid_o = dc_gnt_o && mem_ready_i && !we_q;
    assign dc_wnext_o  = dc_gnt_o && mem_ready_i && we_q;
    assign ic_done_o   = ic_gnt_o && last_beat;
    assign dc_done_o   = dc_gnt_o && last_beat;

    assign mem_req_o   = xfer;
    assign mem_we_o    = xfer && we_q;
    assign mem_addr_o  = xfer ? (base_q + ADDR_W'({beat_q, 2'b00})) : '0;
    assign mem_wdata_o = (xfer && we_q) ? dc_wdata_i : '0;
    assign beat_o      = beat_q;
    assign rdata_o     = mem_rdata_i;

    logic unused_addr_bits;
    assign unused_addr_bits = ^{ic_addr_i[OFF_W-1:0], dc_addr_i[OFF_W-1:0]};

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter; expected beats are queued by the stimulus and checked by a separate monitor.
module tb_mem_port_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        ic_req_i, ic_gnt_o, ic_rvalid_o, ic_done_o;
    logic [31:0] ic_addr_i;
    logic        dc_req_i, dc_we_i, dc_gnt_o, dc_rvalid_o, dc_wnext_o, dc_done_o;
    logic [31:0] dc_addr_i, dc_wdata_i;
    logic [31:0] rdata_o;
    logic [1:0]  beat_o;
    logic        mem_req_o, mem_we_o, mem_ready_i;
    logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .BEATS(4)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .ic_req_i(ic_req_i), .ic_addr_i(ic_addr_i), .ic_gnt_o(ic_gnt_o),
        .ic_rvalid_o(ic_rvalid_o), .ic_done_o(ic_done_o),
        .dc_req_i(dc_req_i), .dc_we_i(dc_we_i), .dc_addr_i(dc_addr_i),
        .dc_wdata_i(dc_wdata_i), .dc_gnt_o(dc_gnt_o), .dc_rvalid_o(dc_rvalid_o),
        .dc_wnext_o(dc_wnext_o), .dc_done_o(dc_done_o),
        .rdata_o(rdata_o), .beat_o(beat_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_ready_i(mem_ready_i), .mem_rdata_i(mem_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    // Memory model: read data encodes the address it came from.
    assign mem_rdata_i = {16'hD00D, mem_addr_o[15:0]};

    typedef struct packed {
        logic        dc;
        logic        we;
        logic [1:0]  beat;
        logic        done;
        logic [31:0] addr;
        logic [31:0] wdata;
    } exp_t;

    exp_t exp_q[$];
    int   pass_cnt = 0;
    int   total_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic push_burst(input logic dc, input logic we, input logic [31:0] base);
        exp_t e;
        for (int k = 0; k < 4; k++) begin
            e.dc    = dc;
            e.we    = we;
            e.beat  = 2'(k);
            e.done  = (k == 3);
            e.addr  = base + 32'(k * 4);
            e.wdata = we ? (32'hA000_0000 + 32'(k)) : 32'h0;
            exp_q.push_back(e);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // mode 0: always ready, 1: ready alternates 0/1, 2: five wait cycles at beat 2.
    task automatic run(input int mode, input int nbursts, input int rearm_dc);
        int   done_cnt = 0;
        int   acc = 0;
        int   stall = 0;
        int   cyc = 0;
        int   wk = 0;
        int   rearm = rearm_dc;
        logic wn, idn, ddn;
        while (done_cnt < nbursts && cyc < 200) begin
            case (mode)
                1:       mem_ready_i = cyc[0];
                2:       mem_ready_i = !(acc == 2 && stall < 5);
                default: mem_ready_i = 1'b1;
            endcase
            @(negedge clk_i);
            wn  = dc_wnext_o;
            idn = ic_done_o;
            ddn = dc_done_o;
            if (mem_req_o && mem_ready_i) acc++;
            else if (mem_req_o && acc == 2) stall++;
            tick();
            cyc++;
            if (wn) begin
                wk++;
                dc_wdata_i = 32'hA000_0000 + 32'(wk);
            end
            if (idn) begin
                ic_req_i = 1'b0;
                done_cnt++;
                acc = 0;
            end
            if (ddn) begin
                if (rearm > 0) rearm--;
                else dc_req_i = 1'b0;
                done_cnt++;
                acc = 0;
                stall = 0;
            end
        end
        chk("burst_done_count", 32'(done_cnt), 32'(nbursts));
        chk("queue_drained", 32'(exp_q.size()), 32'h0);
    endtask

    // Monitor: every cycle compares the port against the head of the expected-beat queue.
    initial begin
        exp_t e;
        logic prev_done = 1'b0;
        forever begin
            @(negedge clk_i);
            if (rst_i) begin
                prev_done = 1'b0;
                continue;
            end
            if (prev_done) chk("idle_gap_after_done", 32'(mem_req_o), 32'h0);
            if (mem_req_o) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_mem_req", 32'(mem_req_o), 32'h0);
                end else begin
                    e = exp_q[0];
                    chk("mem_addr", mem_addr_o, e.addr);
                    chk("mem_we", 32'(mem_we_o), 32'(e.we));
                    chk("beat", 32'(beat_o), 32'(e.beat));
                    chk("gnt", 32'({ic_gnt_o, dc_gnt_o}), 32'({!e.dc, e.dc}));
                    chk("mem_wdata", mem_wdata_o, e.wdata);
                    if (mem_ready_i) begin
                        void'(exp_q.pop_front());
                        chk("strobes",
                            32'({ic_rvalid_o, dc_rvalid_o, dc_wnext_o, ic_done_o, dc_done_o}),
                            32'({!e.dc, e.dc && !e.we, e.we, !e.dc && e.done, e.dc && e.done}));
                        chk("rdata", rdata_o, {16'hD00D, e.addr[15:0]});
                    end else begin
                        chk("wait_strobes",
                            32'({ic_rvalid_o, dc_rvalid_o, dc_wnext_o, ic_done_o, dc_done_o}), 32'h0);
                    end
                end
            end else begin
                chk("idle_outputs",
                    32'({ic_gnt_o, dc_gnt_o, ic_rvalid_o, dc_rvalid_o, dc_wnext_o,
                         ic_done_o, dc_done_o, mem_we_o}), 32'h0);
                chk("idle_addr", mem_addr_o, 32'h0);
            end
            prev_done = ic_done_o | dc_done_o;
        end
    end

    initial begin
        rst_i = 1'b1;
        ic_req_i = 1'b0; ic_addr_i = 32'h0;
        dc_req_i = 1'b0; dc_we_i = 1'b0; dc_addr_i = 32'h0; dc_wdata_i = 32'hDEAD_BEEF;
        mem_ready_i = 1'b0;
        #1;
        chk("rst_outputs",
            32'({ic_gnt_o, ic_rvalid_o, ic_done_o, dc_gnt_o, dc_rvalid_o, dc_wnext_o,
                 dc_done_o, mem_req_o, mem_we_o}), 32'h0);
        chk("rst_beat", 32'(beat_o), 32'h0);
        chk("rst_addr_wdata", mem_addr_o | mem_wdata_o, 32'h0);
        chk("rst_rdata_passthru", rdata_o, 32'hD00D_0000);
        tick();
        rst_i = 1'b0;
        tick();

        // Single I-cache read from a mid-line address.
        ic_addr_i = 32'h0000_1238; ic_req_i = 1'b1; mem_ready_i = 1'b1;
        push_burst(1'b0, 1'b0, 32'h0000_1230);
        tick();
        chk("ic_grant_latency", 32'({ic_gnt_o, dc_gnt_o}), 32'h2);
        run(0, 1, 0);

        // D-cache write-back with alternating ready; address/we changes after grant are ignored.
        dc_we_i = 1'b1; dc_addr_i = 32'h0000_0080; dc_wdata_i = 32'hA000_0000; dc_req_i = 1'b1;
        mem_ready_i = 1'b0;
        push_burst(1'b1, 1'b1, 32'h0000_0080);
        tick();
        chk("dc_grant_latency", 32'({ic_gnt_o, dc_gnt_o}), 32'h1);
        dc_addr_i = 32'h0000_0990; dc_we_i = 1'b0;
        run(1, 1, 0);
        dc_wdata_i = 32'hDEAD_BEEF;

        // Simultaneous requests from a fresh reset: DC, IC, then IC beats re-raised DC.
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        tick();
        ic_addr_i = 32'h0000_2004; ic_req_i = 1'b1;
        dc_we_i = 1'b0; dc_addr_i = 32'h0000_0300; dc_req_i = 1'b1;
        push_burst(1'b1, 1'b0, 32'h0000_0300);
        push_burst(1'b0, 1'b0, 32'h0000_2000);
        push_burst(1'b1, 1'b0, 32'h0000_0300);
        run(0, 3, 1);

        // Wait states at beat 2 of an I-cache read.
        ic_addr_i = 32'h0000_4010; ic_req_i = 1'b1;
        push_burst(1'b0, 1'b0, 32'h0000_4010);
        run(2, 1, 0);

        // Reset in the middle of a D-cache read.
        dc_we_i = 1'b0; dc_addr_i = 32'h0000_0500; dc_req_i = 1'b1; mem_ready_i = 1'b1;
        push_burst(1'b1, 1'b0, 32'h0000_0500);
        tick();
        tick();
        chk("pre_reset_beat", 32'(beat_o), 32'h1);
        #2;
        rst_i = 1'b1;
        #1;
        chk("async_reset_outputs", 32'({mem_req_o, dc_gnt_o, dc_done_o, dc_rvalid_o}), 32'h0);
        chk("async_reset_beat", 32'(beat_o), 32'h0);
        exp_q.delete();
        dc_req_i = 1'b0;
        tick();
        rst_i = 1'b0;
        tick();
        dc_addr_i = 32'h0000_0604; dc_req_i = 1'b1;
        push_burst(1'b1, 1'b0, 32'h0000_0600);
        run(0, 1, 0);

        // Requester drops its request at beat 1; the burst must still finish.
        ic_addr_i = 32'h0000_7000; ic_req_i = 1'b1;
        push_burst(1'b0, 1'b0, 32'h0000_7000);
        tick();
        tick();
        chk("drop_at_beat1", 32'(beat_o), 32'h1);
        ic_req_i = 1'b0;
        ic_addr_i = 32'h0000_FFFF;
        run(0, 1, 0);

        tick();
        tick();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
